// File: rtl/spi_led_slave.sv
// SPI mode-0 slave oversampled in the clk domain; every received word is latched onto the LEDs
// and reported on rx_data, while the reply word is taken from tx_data at each word start.
module spi_led_slave #(
    parameter int                  DATA_W  = 8,
    parameter logic [DATA_W-1:0]   LED_RST = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sspi_clk,
    input  logic              sspi_css,
    input  logic              sspi_si,
    output logic              sspi_so,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ack,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic [DATA_W-1:0] led
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;

    logic              sclk_s1, sclk_s2, sclk_d;
    logic              css_s1, css_s2, css_d;
    logic              si_s1, si_s2;
    logic [1:0]        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] tx_sr;
    logic              word_done;
    logic              rx_pending;
    logic              sclk_rise, sclk_fall, css_rise, css_fall;

    // SCLK edges only count while the chip select is asserted
    assign sclk_rise = sclk_s2 & ~sclk_d & ~css_s2;
    assign sclk_fall = ~sclk_s2 & sclk_d & ~css_s2;
    assign css_rise  = css_s2 & ~css_d;
    assign css_fall  = ~css_s2 & css_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_d  <= 1'b0;
            css_s1  <= 1'b1;
            css_s2  <= 1'b1;
            css_d   <= 1'b1;
            si_s1   <= 1'b0;
            si_s2   <= 1'b0;
        end else begin
            sclk_s1 <= sspi_clk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            css_s1  <= sspi_css;
            css_s2  <= css_s1;
            css_d   <= css_s2;
            si_s1   <= sspi_si;
            si_s2   <= si_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rx_sr      <= '0;
            tx_sr      <= '0;
            word_done  <= 1'b0;
            rx_pending <= 1'b0;
            sspi_so    <= 1'b0;
            tx_ack     <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            led        <= LED_RST;
        end else begin
            tx_ack   <= 1'b0;
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    sspi_so    <= 1'b0;
                    bit_cnt    <= '0;
                    word_done  <= 1'b0;
                    rx_pending <= 1'b0;
                    if (css_fall) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (css_rise) begin
                        state   <= IDLE;
                        sspi_so <= 1'b0;
                    end else begin
                        tx_sr   <= tx_data;
                        tx_ack  <= 1'b1;
                        sspi_so <= tx_data[DATA_W-1];
                        bit_cnt <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Deselect aborts the frame and drops any partially shifted word
                    if (css_rise) begin
                        state      <= IDLE;
                        bit_cnt    <= '0;
                        rx_sr      <= '0;
                        word_done  <= 1'b0;
                        rx_pending <= 1'b0;
                        sspi_so    <= 1'b0;
                    end else begin
                        rx_pending <= 1'b0;
                        if (rx_pending) begin
                            rx_data  <= rx_sr;
                            led      <= rx_sr;
                            rx_valid <= 1'b1;
                        end
                        if (sclk_rise) begin
                            rx_sr <= {rx_sr[DATA_W-2:0], si_s2};
                            if (bit_cnt == LAST_BIT) begin
                                bit_cnt    <= '0;
                                word_done  <= 1'b1;
                                rx_pending <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else if (sclk_fall) begin
                            // The falling edge after a full word starts the next word of a burst
                            if (word_done) begin
                                tx_sr     <= tx_data;
                                tx_ack    <= 1'b1;
                                sspi_so   <= tx_data[DATA_W-1];
                                word_done <= 1'b0;
                            end else begin
                                tx_sr   <= {tx_sr[DATA_W-2:0], 1'b0};
                                sspi_so <= tx_sr[DATA_W-2];
                            end
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    sspi_so <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_led_slave.sv
// Directed bench for spi_led_slave: a table of single-word frames plus hand-written
// sequences for bursts, aborts, deselected clocking, mid-frame reset and edge latency.
module tb_spi_led_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sspi_clk, sspi_css, sspi_si;
    logic       sspi_so;
    logic [7:0] tx_data;
    logic       tx_ack;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] led;

    int n_vec  = 0;
    int n_miss = 0;
    int rv_cnt = 0;
    int ack_cnt = 0;

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] tx;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs[5];

    spi_led_slave #(.DATA_W(8), .LED_RST(8'hFF)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sspi_clk (sspi_clk),
        .sspi_css (sspi_css),
        .sspi_si  (sspi_si),
        .sspi_so  (sspi_so),
        .tx_data  (tx_data),
        .tx_ack   (tx_ack),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .led      (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rx_valid) rv_cnt <= rv_cnt + 1;
        if (tx_ack)   ack_cnt <= ack_cnt + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, input int half, output logic m);
        sspi_si = b;
        repeat (half) @(negedge clk);
        sspi_clk = 1'b1;
        m = sspi_so;
        repeat (half) @(negedge clk);
        sspi_clk = 1'b0;
    endtask

    // Shifts one word; tx_data switches to next_tx right after the last rising edge
    task automatic spi_byte(input logic [7:0] d, input int half, input logic [7:0] next_tx,
                            output logic [7:0] m, output int ack_snap);
        ack_snap = 0;
        for (int i = 7; i >= 0; i--) begin
            sspi_si = d[i];
            repeat (half) @(negedge clk);
            sspi_clk = 1'b1;
            m[i] = sspi_so;
            if (i == 0) tx_data = next_tx;
            repeat (half) @(negedge clk);
            if (i == 0) ack_snap = ack_cnt;
            sspi_clk = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] mosi, input logic [7:0] tx,
                                 output logic [7:0] miso, output int acks, output int rxv);
        int a0, r0, snap;
        a0 = ack_cnt;
        r0 = rv_cnt;
        tx_data = tx;
        sspi_css = 1'b0;
        repeat (8) @(negedge clk);
        spi_byte(mosi, 8, tx, miso, snap);
        repeat (8) @(negedge clk);
        sspi_css = 1'b1;
        repeat (10) @(negedge clk);
        acks = snap - a0;
        rxv = rv_cnt - r0;
    endtask

    initial begin
        logic [7:0] m0, m1;
        logic       mb;
        int         acks, rxv, a0, r0, s0, s1;

        vecs[0] = '{8'hA5, 8'h3C, 8'hA5, 8'h3C};
        vecs[1] = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        vecs[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        vecs[3] = '{8'h81, 8'h7E, 8'h81, 8'h7E};
        vecs[4] = '{8'h36, 8'hC9, 8'h36, 8'hC9};

        rst_n = 1'b0;
        sspi_clk = 1'b0;
        sspi_css = 1'b1;
        sspi_si = 1'b0;
        tx_data = 8'h00;
        repeat (4) @(negedge clk);
        checkOutput("reset_led", led, 8'hFF);
        checkOutput("reset_rx_data", rx_data, 8'h00);
        checkOutput("reset_so", sspi_so, 1'b0);
        checkOutput("reset_rx_valid", rx_valid, 1'b0);
        checkOutput("reset_tx_ack", tx_ack, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        $display("[TB] abort after 5 clocks, then full 0x5A frame");
        r0 = rv_cnt;
        sspi_css = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 5; i++) spi_bit(1'b1, 8, mb);
        repeat (8) @(negedge clk);
        sspi_css = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("abort_rx_valid", rv_cnt - r0, 0);
        checkOutput("abort_led", led, 8'hFF);
        applyStimulus(8'h5A, 8'h00, m0, acks, rxv);
        checkOutput("after_abort_rx", rx_data, 8'h5A);
        checkOutput("after_abort_led", led, 8'h5A);
        checkOutput("after_abort_rx_valid", rxv, 1);

        $display("[TB] sclk toggling while deselected");
        r0 = rv_cnt;
        a0 = ack_cnt;
        for (int i = 0; i < 16; i++) begin
            sspi_si = 1'($urandom);
            repeat (4) @(negedge clk);
            sspi_clk = ~sspi_clk;
        end
        repeat (6) @(negedge clk);
        checkOutput("ignore_rx_valid", rv_cnt - r0, 0);
        checkOutput("ignore_tx_ack", ack_cnt - a0, 0);
        checkOutput("ignore_so", sspi_so, 1'b0);
        checkOutput("ignore_led", led, 8'h5A);

        $display("[TB] single-word frame table");
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].mosi, vecs[v].tx, m0, acks, rxv);
            checkOutput($sformatf("vec%0d_rx_data", v), rx_data, vecs[v].exp_rx);
            checkOutput($sformatf("vec%0d_led", v), led, vecs[v].exp_rx);
            checkOutput($sformatf("vec%0d_miso", v), m0, vecs[v].exp_miso);
            checkOutput($sformatf("vec%0d_rx_valid", v), rxv, 1);
            checkOutput($sformatf("vec%0d_tx_ack", v), acks, 1);
        end

        $display("[TB] two-word burst");
        r0 = rv_cnt;
        a0 = ack_cnt;
        tx_data = 8'h11;
        sspi_css = 1'b0;
        repeat (8) @(negedge clk);
        spi_byte(8'h01, 8, 8'h22, m0, s0);
        spi_byte(8'h80, 8, 8'h22, m1, s1);
        repeat (8) @(negedge clk);
        sspi_css = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("burst_miso0", m0, 8'h11);
        checkOutput("burst_miso1", m1, 8'h22);
        checkOutput("burst_tx_ack", s1 - a0, 2);
        checkOutput("burst_rx_valid", rv_cnt - r0, 2);
        checkOutput("burst_led", led, 8'h80);
        checkOutput("burst_rx_data", rx_data, 8'h80);

        $display("[TB] reset in the middle of a frame");
        tx_data = 8'h3C;
        sspi_css = 1'b0;
        repeat (8) @(negedge clk);
        spi_bit(1'b1, 8, mb);
        spi_bit(1'b1, 8, mb);
        spi_bit(1'b0, 8, mb);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_led", led, 8'hFF);
        checkOutput("midreset_rx_data", rx_data, 8'h00);
        checkOutput("midreset_so", sspi_so, 1'b0);
        sspi_css = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        applyStimulus(8'hC3, 8'h00, m0, acks, rxv);
        checkOutput("postreset_led", led, 8'hC3);
        checkOutput("postreset_rx_data", rx_data, 8'hC3);
        checkOutput("postreset_rx_valid", rxv, 1);

        $display("[TB] sclk at clk/4, 0xFF then 0x00");
        m0 = 8'hFF;
        m1 = 8'h00;
        sspi_css = 1'b0;
        repeat (8) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            for (int i = 7; i >= 0; i--) begin
                sspi_si = (w == 0) ? m0[i] : m1[i];
                repeat (2) @(negedge clk);
                sspi_clk = 1'b1;
                repeat (2) @(negedge clk);
                sspi_clk = 1'b0;
                if (i == 0) begin
                    @(negedge clk);
                    checkOutput($sformatf("timing_w%0d_early", w), rx_valid, 1'b0);
                    @(negedge clk);
                    checkOutput($sformatf("timing_w%0d_valid", w), rx_valid, 1'b1);
                    checkOutput($sformatf("timing_w%0d_rx_data", w), rx_data, (w == 0) ? 8'hFF : 8'h00);
                end
            end
        end
        repeat (4) @(negedge clk);
        sspi_css = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("timing_led", led, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
